// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one arithmetic right shifter across NUM_REQ requesters, with a
// single registered output slot. Define SHIFT_ARB_ROUND_EN to round half-up instead of truncating.
module shift_arbiter #(
    parameter int DATA_BITS = 48,
    parameter int SHIFT_W   = 5,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ*SHIFT_W-1:0]   req_shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_BITS-1:0]         out_data,
    output logic [ID_W-1:0]              out_id,
    output logic                         out_range_err
);

    localparam int SHIFT_MIN = 5;
    localparam int SHIFT_MAX = 25;

    logic                        out_valid_q, out_valid_d;
    logic signed [DATA_BITS-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]             out_id_q, out_id_d;
    logic                        out_err_q, out_err_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;

    logic                        slot_free;
    logic                        gnt_found;
    logic [ID_W-1:0]             gnt_idx;
    logic                        accept;
    logic signed [DATA_BITS-1:0] sel_data;
    logic [SHIFT_W-1:0]          sel_shift;
    logic                        range_ok;

    function automatic logic shift_in_range(input logic [SHIFT_W-1:0] n);
        return (n >= SHIFT_W'(SHIFT_MIN)) && (n <= SHIFT_W'(SHIFT_MAX));
    endfunction

    // Only meaningful for in-range n; out-of-range results are forced to zero by the caller.
    function automatic logic signed [DATA_BITS-1:0] shift_op(
        input logic signed [DATA_BITS-1:0] op,
        input logic [SHIFT_W-1:0]          n
    );
`ifdef SHIFT_ARB_ROUND_EN
        logic signed [DATA_BITS:0] ext;
        logic signed [DATA_BITS:0] bias;
        logic signed [DATA_BITS:0] sum;
        ext  = {op[DATA_BITS-1], op};
        bias = {{DATA_BITS{1'b0}}, 1'b1} << (n - 1'b1);
        sum  = ext + bias;
        sum  = sum >>> n;
        return sum[DATA_BITS-1:0];
`else
        return op >>> n;
`endif
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = slot_free && gnt_found;

    // Circular search starting at rr_ptr_q; first valid requester wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        int              pos;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = ID_W'(pos);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rstn && accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_data  = req_data[int'(gnt_idx)*DATA_BITS +: DATA_BITS];
    assign sel_shift = req_shift[int'(gnt_idx)*SHIFT_W +: SHIFT_W];
    assign range_ok  = shift_in_range(sel_shift);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_err_d   = out_err_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = range_ok ? shift_op(sel_data, sel_shift) : '0;
            out_id_d    = gnt_idx;
            out_err_d   = !range_ok;
            rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_err_q   <= out_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_id        = out_id_q;
    assign out_range_err = out_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: expected results are queued at each predicted accept
// and compared whenever the DUT hands a result downstream.
module tb_shift_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [191:0] req_data;
    logic [19:0]  req_shift;
    logic         out_valid;
    logic         out_ready;
    logic [47:0]  out_data;
    logic [1:0]   out_id;
    logic         out_range_err;

    logic [47:0]  d [4];
    logic [4:0]   s [4];

    typedef struct packed {
        logic [47:0] data;
        logic [1:0]  id;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0] m_ptr = 2'd0;
    logic       m_ov = 1'b0;
    logic       m_found = 1'b0;
    logic [1:0] m_gnt = 2'd0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_data[g*48 +: 48] = d[g];
        assign req_shift[g*5 +: 5]  = s[g];
    end

    shift_arbiter #(.DATA_BITS(48), .SHIFT_W(5), .NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_range_err(out_range_err)
    );

    function automatic logic [47:0] m_shift(input logic [47:0] v, input logic [4:0] n);
        longint x;
        if (n < 5'd5 || n > 5'd25) return 48'd0;
        x = longint'($signed(v));
`ifdef SHIFT_ARB_ROUND_EN
        x = x + (longint'(1) << (int'(n) - 1));
`endif
        x = x >>> n;
        return x[47:0];
    endfunction

    // Sets the inputs for the coming edge and predicts the grant.
    task automatic drive(input logic [3:0] v, input logic rdy, output logic [3:0] exp_rdy);
        logic [1:0] idx;
        req_valid = v;
        out_ready = rdy;
        exp_rdy   = 4'd0;
        m_found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!m_found && v[idx]) begin
                m_found = 1'b1;
                m_gnt   = idx;
            end
        end
        if (!(!m_ov || rdy)) m_found = 1'b0;
        if (m_found) exp_rdy[m_gnt] = 1'b1;
    endtask

    task automatic commit();
        exp_t e;
        @(posedge clk);
        if (m_found) begin
            e.data = m_shift(d[m_gnt], s[m_gnt]);
            e.id   = m_gnt;
            e.err  = (s[m_gnt] < 5'd5) || (s[m_gnt] > 5'd25);
            sb.push_back(e);
            m_ptr = m_gnt + 2'd1;
            m_ov  = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        m_found = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            checks++;
            if (out_valid !== m_ov) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", out_valid, m_ov);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id %0d data %h, want no result", out_id, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_range_err !== e.err) begin
                        errors++;
                        $display("FAIL sb_result: got data %h id %0d err %b want data %h id %0d err %b",
                                 out_data, out_id, out_range_err, e.data, e.id, e.err);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin d[i] = 48'h1234; s[i] = 5'd8; end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_id, out_range_err, req_ready} !== 56'd0) begin
            errors++;
            $display("FAIL reset_state: got v%b d%h id%0d e%b rdy%b want all zero",
                     out_valid, out_data, out_id, out_range_err, req_ready);
        end
        req_valid = 4'h0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] er;
        d[2] = 48'h0000_0000_1000; s[2] = 5'd8;
        drive(4'b0100, 1'b1, er);
        @(negedge clk);
        checks++;
        if (req_ready !== er || er !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b want %b", req_ready, er);
        end
        commit();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 48'h10 || out_id !== 2'd2 || out_range_err !== 1'b0) begin
            errors++;
            $display("FAIL single_out: got v%b d%h id%0d e%b want v1 d10 id2 e0",
                     out_valid, out_data, out_id, out_range_err);
        end
        drive(4'b0000, 1'b1, er);
        commit();
    endtask

    task automatic test_negative();
        logic [3:0] er;
        d[0] = 48'hFFFF_FFFF_FF00; s[0] = 5'd5;
        drive(4'b0001, 1'b1, er);
        @(negedge clk);
        checks++;
        if (req_ready !== er) begin errors++; $display("FAIL neg_ready: got %b want %b", req_ready, er); end
        commit();
        checks++;
        if (out_data !== 48'hFFFF_FFFF_FFF8 || out_range_err !== 1'b0) begin
            errors++; $display("FAIL neg_out: got %h e%b want fffffffffff8 e0", out_data, out_range_err);
        end
        drive(4'b0000, 1'b1, er);
        commit();
    endtask

    task automatic test_range();
        logic [3:0] er;
        logic [4:0] ns [7] = '{5'd3, 5'd26, 5'd4, 5'd5, 5'd25, 5'd0, 5'd31};
        for (int i = 0; i < 7; i++) begin
            d[1] = (i == 4) ? 48'h8000_0000_0000 : 48'h1234;
            s[1] = ns[i];
            drive(4'b0010, 1'b1, er);
            @(negedge clk);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL range_ready: got %b want %b", req_ready, er); end
            commit();
            if (i < 2) begin
                checks++;
                if (out_data !== 48'd0 || out_range_err !== 1'b1) begin
                    errors++; $display("FAIL range_err n=%0d: got %h e%b want 0 e1", ns[i], out_data, out_range_err);
                end
            end
        end
        drive(4'b0000, 1'b1, er);
        commit();
    endtask

    task automatic test_round();
        logic [3:0]  er;
        logic [47:0] want;
`ifdef SHIFT_ARB_ROUND_EN
        want = 48'd1;
`else
        want = 48'd0;
`endif
        d[3] = 48'h18; s[3] = 5'd5;
        drive(4'b1000, 1'b1, er);
        @(negedge clk);
        commit();
        checks++;
        if (out_data !== want || out_range_err !== 1'b0) begin
            errors++; $display("FAIL round: got %h e%b want %h e0", out_data, out_range_err, want);
        end
        drive(4'b0000, 1'b1, er);
        commit();
    endtask

    task automatic test_reset_mid();
        logic [3:0] er;
        for (int i = 0; i < 4; i++) begin d[i] = 48'h100 * (i + 1); s[i] = 5'd6; end
        drive(4'b0100, 1'b1, er);
        commit();
        drive(4'b0100, 1'b0, er);
        #2;
        rstn = 1'b0;
        req_valid = 4'h0;
        #1;
        checks++;
        if ({out_valid, out_data, out_id, out_range_err, req_ready} !== 56'd0) begin
            errors++; $display("FAIL reset_mid: got v%b d%h id%0d rdy%b want zero", out_valid, out_data, out_id, req_ready);
        end
        sb.delete();
        m_ptr = 2'd0; m_ov = 1'b0; m_found = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(4'b1111, 1'b1, er);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        end
        commit();
    endtask

    task automatic test_rr();
        logic [3:0] er;
        for (int k = 1; k < 9; k++) begin
            for (int i = 0; i < 4; i++) begin d[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF; s[i] = 5'(5 + k); end
            drive(4'b1111, 1'b1, er);
            @(negedge clk);
            checks++;
            if (req_ready !== (4'b0001 << (k % 4)) || req_ready !== er) begin
                errors++; $display("FAIL rr_seq %0d: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            commit();
            checks++;
            if (out_id !== 2'(k % 4) || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_id %0d: got id%0d v%b want id%0d v1", k, out_id, out_valid, k % 4);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]  er;
        logic [47:0] held_d;
        logic [1:0]  held_id;
        logic        held_e;
        held_d = out_data; held_id = out_id; held_e = out_range_err;
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0, er);
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== held_d
                || out_id !== held_id || out_range_err !== held_e) begin
                errors++;
                $display("FAIL stall_hold %0d: got rdy%b v%b d%h id%0d want rdy0000 v1 d%h id%0d",
                         c, req_ready, out_valid, out_data, out_id, held_d, held_id);
            end
            commit();
        end
        drive(4'b1111, 1'b1, er);
        @(negedge clk);
        checks++;
        if (req_ready !== er || er !== (4'b0001 << (held_id + 2'd1))) begin
            errors++; $display("FAIL stall_resume: got %b want %b", req_ready, er);
        end
        commit();
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                s[i] = 5'($urandom_range(0, 31));
            end
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), er);
            @(negedge clk);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL rand_ready %0d: got %b want %b", k, req_ready, er); end
            commit();
        end
    endtask

    task automatic test_drain();
        logic [3:0] er;
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 1'b1, er);
            commit();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain: got %0d pending results want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_range();
        test_round();
        test_reset_mid();
        test_rr();
        test_stall();
        test_random();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
